// File: rtl/char_motion_arbiter.sv
// -----------------------------------------------------------------------------
// char_motion_arbiter
//
// Movement controller for N characters on the OLED playfield. Each move_tick
// starts a sweep that visits the characters in index order. Each character
// takes two cycles:
//   CALC  - resolve the held keys, update the direction and form a candidate
//   CHECK - test the candidate for collision, then commit it or reject it
// Registered positions and directions drive the sprite BRAM address
// generators.
//
// Optional build macro:
//   CHAR_MOTION_WRAP_EN - a move past an edge wraps to the opposite edge.
//                         Without it, positions clamp at the edge.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   move_tick  in   single-cycle pulse that starts a sweep
//   move_req   in   4*N_CHARS key bits {L,R,U,D}; char i is in [4i+3:4i]
//   x_pos      out  packed registered x positions, char0 in the LSBs
//   y_pos      out  packed registered y positions, char0 in the LSBs
//   dir        out  packed directions: 00 up, 01 down, 10 left, 11 right
//   blocked    out  per-character flag: move rejected in the last sweep
//   busy       out  high while a sweep is in progress
//   sweep_done out  one-cycle pulse when a sweep ends
//   overrun    out  sticky; move_tick arrived while a sweep was running
// -----------------------------------------------------------------------------
module char_motion_arbiter #(
  parameter int N_CHARS = 4,
  parameter int X_W     = 7,
  parameter int Y_W     = 6,
  parameter int CHAR_W  = 20,
  parameter int CHAR_H  = 20,
  parameter int X_MAX   = 75,
  parameter int Y_MAX   = 43,
  parameter int STEP    = 1,
  parameter logic [X_W*N_CHARS-1:0] INIT_X = {7'd60, 7'd10, 7'd60, 7'd10},
  parameter logic [Y_W*N_CHARS-1:0] INIT_Y = {6'd40, 6'd40, 6'd10, 6'd10}
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   move_tick,
  input  logic [4*N_CHARS-1:0]   move_req,
  output logic [X_W*N_CHARS-1:0] x_pos,
  output logic [Y_W*N_CHARS-1:0] y_pos,
  output logic [2*N_CHARS-1:0]   dir,
  output logic [N_CHARS-1:0]     blocked,
  output logic                   busy,
  output logic                   sweep_done,
  output logic                   overrun
);

  localparam int IDX_W = (N_CHARS > 1) ? $clog2(N_CHARS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHARS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {IDLE, CALC, CHECK, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [X_W-1:0]   x_q   [N_CHARS];
  logic [Y_W-1:0]   y_q   [N_CHARS];
  logic [1:0]       dir_q [N_CHARS];
  logic [N_CHARS-1:0] blocked_q;
  logic [X_W-1:0]   cand_x;
  logic [Y_W-1:0]   cand_y;
  logic             cand_mv;
  logic             overrun_q;
  logic [3:0]       req;
  logic             hit;

  // One STEP along x, done one bit wider so the sum cannot wrap silently.
  function automatic logic [X_W-1:0] step_x(input logic [X_W-1:0] c, input logic inc);
    logic [X_W:0] e, s, m;
    e = {1'b0, c};
    s = (X_W+1)'(STEP);
    m = (X_W+1)'(X_MAX);
    if (inc) begin
      if (e + s > m) begin
`ifdef CHAR_MOTION_WRAP_EN
        step_x = X_W'(e + s - m - (X_W+1)'(1));
`else
        step_x = X_W'(m);
`endif
      end else begin
        step_x = X_W'(e + s);
      end
    end else begin
      if (e < s) begin
`ifdef CHAR_MOTION_WRAP_EN
        step_x = X_W'(m + (X_W+1)'(1) + e - s);
`else
        step_x = '0;
`endif
      end else begin
        step_x = X_W'(e - s);
      end
    end
  endfunction

  // One STEP along y, done one bit wider so the sum cannot wrap silently.
  function automatic logic [Y_W-1:0] step_y(input logic [Y_W-1:0] c, input logic inc);
    logic [Y_W:0] e, s, m;
    e = {1'b0, c};
    s = (Y_W+1)'(STEP);
    m = (Y_W+1)'(Y_MAX);
    if (inc) begin
      if (e + s > m) begin
`ifdef CHAR_MOTION_WRAP_EN
        step_y = Y_W'(e + s - m - (Y_W+1)'(1));
`else
        step_y = Y_W'(m);
`endif
      end else begin
        step_y = Y_W'(e + s);
      end
    end else begin
      if (e < s) begin
`ifdef CHAR_MOTION_WRAP_EN
        step_y = Y_W'(m + (Y_W+1)'(1) + e - s);
`else
        step_y = '0;
`endif
      end else begin
        step_y = Y_W'(e - s);
      end
    end
  endfunction

  // Bounding-box overlap. Two extra bits keep coordinate + size from wrapping.
  function automatic logic overlaps(input logic [X_W-1:0] ax, input logic [Y_W-1:0] ay,
                                    input logic [X_W-1:0] bx, input logic [Y_W-1:0] by);
    logic [X_W+1:0] axe, bxe, cw;
    logic [Y_W+1:0] aye, bye, ch;
    axe = {2'b00, ax};
    bxe = {2'b00, bx};
    cw  = (X_W+2)'(CHAR_W);
    aye = {2'b00, ay};
    bye = {2'b00, by};
    ch  = (Y_W+2)'(CHAR_H);
    return (axe < bxe + cw) && (axe + cw > bxe) && (aye < bye + ch) && (aye + ch > bye);
  endfunction

  // Keys of the character being processed, sampled in its CALC cycle.
  always_comb begin
    req = move_req[{idx_q, 2'b00} +: 4];
  end

  // The candidate is tested against every other character's current register.
  // Characters with a lower index have already committed in this sweep.
  always_comb begin
    hit = 1'b0;
    for (int j = 0; j < N_CHARS; j++) begin
      if ((IDX_W'(j) != idx_q) && overlaps(cand_x, cand_y, x_q[j], y_q[j])) begin
        hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    sweep_done = 1'b0;
    case (state_q)
      IDLE:  if (move_tick) state_d = CALC;
      CALC:  begin
        busy    = 1'b1;
        state_d = CHECK;
      end
      CHECK: begin
        busy    = 1'b1;
        state_d = (idx_q == LAST_IDX) ? DONE : CALC;
      end
      DONE:  begin
        sweep_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CHARS; i++) begin
        x_q[i]   <= INIT_X[i*X_W +: X_W];
        y_q[i]   <= INIT_Y[i*Y_W +: Y_W];
        dir_q[i] <= 2'b00;
      end
      blocked_q <= '0;
      idx_q     <= '0;
      cand_x    <= '0;
      cand_y    <= '0;
      cand_mv   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (move_tick && (state_q != IDLE)) overrun_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (move_tick) begin
            idx_q     <= '0;
            blocked_q <= '0;
          end
        end
        // ---- CALC: key priority L > R > U > D, form candidate ----
        CALC: begin
          cand_x  <= x_q[idx_q];
          cand_y  <= y_q[idx_q];
          cand_mv <= 1'b1;
          if (req[3]) begin
            dir_q[idx_q] <= 2'b10;
            cand_x       <= step_x(x_q[idx_q], 1'b0);
          end else if (req[2]) begin
            dir_q[idx_q] <= 2'b11;
            cand_x       <= step_x(x_q[idx_q], 1'b1);
          end else if (req[1]) begin
            dir_q[idx_q] <= 2'b00;
            cand_y       <= step_y(y_q[idx_q], 1'b0);
          end else if (req[0]) begin
            dir_q[idx_q] <= 2'b01;
            cand_y       <= step_y(y_q[idx_q], 1'b1);
          end else begin
            cand_mv <= 1'b0;
          end
        end
        // ---- CHECK: commit or reject, advance to next character ----
        CHECK: begin
          // A character with no key held stays put and is never blocked,
          // even if it already overlaps another character.
          if (cand_mv) begin
            if (hit) begin
              blocked_q[idx_q] <= 1'b1;
            end else begin
              x_q[idx_q] <= cand_x;
              y_q[idx_q] <= cand_y;
            end
          end
          if (idx_q != LAST_IDX) idx_q <= idx_q + IDX_ONE;
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < N_CHARS; g++) begin : g_pack
    assign x_pos[g*X_W +: X_W] = x_q[g];
    assign y_pos[g*Y_W +: Y_W] = y_q[g];
    assign dir[2*g +: 2]       = dir_q[g];
  end

  assign blocked = blocked_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_char_motion_arbiter.sv
module tb_char_motion_arbiter;
  localparam int NC = 4, XW = 7, YW = 6, CW = 20, CH = 20;
  localparam int XMAX = 75, YMAX = 43, STEP = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic move_tick = 1'b0;
  logic [4*NC-1:0]  move_req = '0;
  logic [XW*NC-1:0] x_pos;
  logic [YW*NC-1:0] y_pos;
  logic [2*NC-1:0]  dir;
  logic [NC-1:0]    blocked;
  logic busy, sweep_done, overrun;

  int checks = 0;
  int errors = 0;

  // Reference model state: plain integers per character.
  int mx[NC], my[NC], md[NC];
  bit mb[NC];
  bit movr;

  char_motion_arbiter dut (
    .clk(clk), .reset(reset), .move_tick(move_tick), .move_req(move_req),
    .x_pos(x_pos), .y_pos(y_pos), .dir(dir), .blocked(blocked),
    .busy(busy), .sweep_done(sweep_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic int mstep(int c, bit inc, int lim);
    if (inc) begin
      if (c + STEP > lim) begin
`ifdef CHAR_MOTION_WRAP_EN
        return c + STEP - lim - 1;
`else
        return lim;
`endif
      end
      return c + STEP;
    end
    if (c < STEP) begin
`ifdef CHAR_MOTION_WRAP_EN
      return lim + 1 + c - STEP;
`else
      return 0;
`endif
    end
    return c - STEP;
  endfunction

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    mx = '{10, 60, 10, 60};
    my = '{10, 10, 40, 40};
    for (int i = 0; i < NC; i++) begin
      md[i] = 0;
      mb[i] = 0;
    end
    movr = 0;
  endtask

  // One sweep with a constant key map: characters visited in order, each
  // sees the already-updated positions of the others.
  task automatic model_sweep(input logic [4*NC-1:0] r);
    logic [3:0] k;
    int cx, cy;
    bit mv, h;
    for (int i = 0; i < NC; i++) mb[i] = 0;
    for (int i = 0; i < NC; i++) begin
      k  = r[4*i +: 4];
      cx = mx[i];
      cy = my[i];
      mv = 1;
      if (k[3])      begin md[i] = 2; cx = mstep(cx, 0, XMAX); end
      else if (k[2]) begin md[i] = 3; cx = mstep(cx, 1, XMAX); end
      else if (k[1]) begin md[i] = 0; cy = mstep(cy, 0, YMAX); end
      else if (k[0]) begin md[i] = 1; cy = mstep(cy, 1, YMAX); end
      else mv = 0;
      if (mv) begin
        h = 0;
        for (int j = 0; j < NC; j++)
          if (j != i && iabs(cx - mx[j]) < CW && iabs(cy - my[j]) < CH) h = 1;
        if (h) mb[i] = 1;
        else begin
          mx[i] = cx;
          my[i] = cy;
        end
      end
    end
  endtask

  function automatic logic [XW*NC-1:0] exp_x();
    logic [XW*NC-1:0] v;
    for (int i = 0; i < NC; i++) v[i*XW +: XW] = XW'(mx[i]);
    return v;
  endfunction
  function automatic logic [YW*NC-1:0] exp_y();
    logic [YW*NC-1:0] v;
    for (int i = 0; i < NC; i++) v[i*YW +: YW] = YW'(my[i]);
    return v;
  endfunction
  function automatic logic [2*NC-1:0] exp_dir();
    logic [2*NC-1:0] v;
    for (int i = 0; i < NC; i++) v[2*i +: 2] = 2'(md[i]);
    return v;
  endfunction
  function automatic logic [NC-1:0] exp_blk();
    logic [NC-1:0] v;
    for (int i = 0; i < NC; i++) v[i] = mb[i];
    return v;
  endfunction

  function automatic logic [4*NC-1:0] keyreq(int ch, logic [3:0] k);
    logic [4*NC-1:0] r;
    r = '0;
    r[4*ch +: 4] = k;
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    move_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Leaves the bench in the cycle after the one that carried move_tick.
  task automatic start_tick(input logic [4*NC-1:0] r);
    @(negedge clk);
    move_req  = r;
    move_tick = 1'b1;
    @(negedge clk);
    move_tick = 1'b0;
  endtask

  // Counts cycles from the tick to the sweep_done pulse, bounded.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!sweep_done && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (x_pos !== exp_x()) begin errors++; $display("FAIL reset_x got %h exp %h", x_pos, exp_x()); end
    checks++; if (y_pos !== exp_y()) begin errors++; $display("FAIL reset_y got %h exp %h", y_pos, exp_y()); end
    checks++; if (dir !== '0) begin errors++; $display("FAIL reset_dir got %h exp 0", dir); end
    checks++; if (blocked !== '0) begin errors++; $display("FAIL reset_blocked got %h exp 0", blocked); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (sweep_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", sweep_done); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
  endtask

  task automatic test_left_clamp();
    int cyc;
    do_reset();
    for (int t = 1; t <= 12; t++) begin
      start_tick(keyreq(0, 4'b1000));
      wait_done(cyc);
      model_sweep(keyreq(0, 4'b1000));
      checks++; if (cyc !== 9) begin errors++; $display("FAIL left_latency tick %0d got %0d exp 9", t, cyc); end
      checks++; if (x_pos !== exp_x()) begin errors++; $display("FAIL left_x tick %0d got %h exp %h", t, x_pos, exp_x()); end
      checks++; if (dir !== exp_dir()) begin errors++; $display("FAIL left_dir tick %0d got %h exp %h", t, dir, exp_dir()); end
      checks++; if (blocked !== exp_blk()) begin errors++; $display("FAIL left_blocked tick %0d got %h exp %h", t, blocked, exp_blk()); end
    end
  endtask

  task automatic test_right_block();
    int cyc;
    do_reset();
    for (int t = 1; t <= 34; t++) begin
      start_tick(keyreq(0, 4'b0100));
      wait_done(cyc);
      model_sweep(keyreq(0, 4'b0100));
      checks++; if (x_pos !== exp_x()) begin errors++; $display("FAIL right_x tick %0d got %h exp %h", t, x_pos, exp_x()); end
      checks++; if (dir !== exp_dir()) begin errors++; $display("FAIL right_dir tick %0d got %h exp %h", t, dir, exp_dir()); end
      checks++; if (blocked !== exp_blk()) begin errors++; $display("FAIL right_blocked tick %0d got %h exp %h", t, blocked, exp_blk()); end
    end
  endtask

  task automatic test_converge();
    int cyc;
    logic [4*NC-1:0] r;
    do_reset();
    r = keyreq(0, 4'b0001) | keyreq(2, 4'b0010);
    for (int t = 1; t <= 14; t++) begin
      start_tick(r);
      wait_done(cyc);
      model_sweep(r);
      checks++; if (y_pos !== exp_y()) begin errors++; $display("FAIL conv_y tick %0d got %h exp %h", t, y_pos, exp_y()); end
      checks++; if (blocked !== exp_blk()) begin errors++; $display("FAIL conv_blocked tick %0d got %h exp %h", t, blocked, exp_blk()); end
      checks++; if (dir !== exp_dir()) begin errors++; $display("FAIL conv_dir tick %0d got %h exp %h", t, dir, exp_dir()); end
    end
  endtask

  task automatic test_random();
    int cyc;
    logic [4*NC-1:0] r;
    do_reset();
    for (int t = 1; t <= 40; t++) begin
      r = (4*NC)'($urandom);
      start_tick(r);
      wait_done(cyc);
      model_sweep(r);
      checks++; if (x_pos !== exp_x()) begin errors++; $display("FAIL rand_x tick %0d got %h exp %h", t, x_pos, exp_x()); end
      checks++; if (y_pos !== exp_y()) begin errors++; $display("FAIL rand_y tick %0d got %h exp %h", t, y_pos, exp_y()); end
      checks++; if (dir !== exp_dir()) begin errors++; $display("FAIL rand_dir tick %0d got %h exp %h", t, dir, exp_dir()); end
      checks++; if (blocked !== exp_blk()) begin errors++; $display("FAIL rand_blocked tick %0d got %h exp %h", t, blocked, exp_blk()); end
      checks++; if (overrun !== movr) begin errors++; $display("FAIL rand_overrun tick %0d got %b exp %b", t, overrun, movr); end
    end
  endtask

  task automatic test_overrun();
    int cyc, pulses;
    logic [4*NC-1:0] r;
    do_reset();
    r = keyreq(1, 4'b0001) | keyreq(3, 4'b1000);
    start_tick(r);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovr_busy got %b exp 1", busy); end
    cyc = 1;
    repeat (2) begin @(negedge clk); cyc++; end
    move_tick = 1'b1;
    @(negedge clk);
    cyc++;
    move_tick = 1'b0;
    movr = 1;
    while (!sweep_done && cyc < 30) begin @(negedge clk); cyc++; end
    model_sweep(r);
    checks++; if (cyc !== 9) begin errors++; $display("FAIL ovr_latency got %0d exp 9", cyc); end
    checks++; if (overrun !== movr) begin errors++; $display("FAIL ovr_flag got %b exp %b", overrun, movr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovr_busy_done got %b exp 0", busy); end
    checks++; if (x_pos !== exp_x()) begin errors++; $display("FAIL ovr_x got %h exp %h", x_pos, exp_x()); end
    checks++; if (y_pos !== exp_y()) begin errors++; $display("FAIL ovr_y got %h exp %h", y_pos, exp_y()); end
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (sweep_done || busy) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL ovr_second_sweep got %0d active cycles exp 0", pulses); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b exp 1", overrun); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    do_reset();
    start_tick(keyreq(0, 4'b0100) | keyreq(1, 4'b0100));
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    model_reset();
    checks++; if (x_pos !== exp_x()) begin errors++; $display("FAIL rstmid_x got %h exp %h", x_pos, exp_x()); end
    checks++; if (y_pos !== exp_y()) begin errors++; $display("FAIL rstmid_y got %h exp %h", y_pos, exp_y()); end
    checks++; if (dir !== '0) begin errors++; $display("FAIL rstmid_dir got %h exp 0", dir); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    checks++; if (sweep_done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b exp 0", sweep_done); end
    reset = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (sweep_done) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rstmid_pulse got %0d exp 0", pulses); end
    checks++; if (x_pos !== exp_x()) begin errors++; $display("FAIL rstmid_x_after got %h exp %h", x_pos, exp_x()); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_left_clamp();
    test_right_block();
    test_converge();
    test_random();
    test_overrun();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
